// File: rtl/demux_sample_ctrl.sv
// Capture sequencer for the 16->32 channel demux front end: selects raw or demuxed
// samples, applies the sample-rate divider and gates output through IDLE/ARMED/RUN.
module demux_sample_ctrl #(
    parameter int unsigned DIV_W = 24,
    parameter int unsigned DW    = 32
) (
    input  logic             clock,
    input  logic             extReset,
    input  logic             wr_divider,
    input  logic             wr_flags,
    input  logic [DIV_W-1:0] cfg_data,
    input  logic             arm,
    input  logic             disarm,
    input  logic             sti_valid,
    input  logic [DW-1:0]    raw_data,
    input  logic [DW-1:0]    demux_data,
    output logic             sto_valid,
    output logic [DW-1:0]    sto_data,
    output logic             demux_mode,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StRun     = 2'd2,
        StInvalid = 2'd3
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [DIV_W-1:0]   r_pend_div;
    logic               r_pend_demux;
    logic [DIV_W-1:0]   r_act_div;
    logic               r_demux_mode;
    logic [DIV_W-1:0]   r_cnt;
    logic               r_sto_valid;
    logic [DW-1:0]      r_sto_data;

    logic [DIV_W-1:0]   w_pend_div_nxt;
    logic               w_pend_demux_nxt;
    logic               w_load_cfg;
    logic               w_emit;
    logic               w_cnt_dec;

    // Same-cycle config writes are forwarded so a taken arm sees the new value.
    assign w_pend_div_nxt   = wr_divider ? cfg_data : r_pend_div;
    assign w_pend_demux_nxt = wr_flags ? cfg_data[0] : r_pend_demux;

    always_ff @(posedge clock) begin
        if (extReset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (arm && !disarm) w_state_nxt = StArmed;
            end
            StArmed: begin
                if (disarm)         w_state_nxt = StIdle;
                else if (sti_valid) w_state_nxt = StRun;
            end
            StRun: begin
                if (disarm) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_load_cfg = 1'b0;
        w_emit     = 1'b0;
        w_cnt_dec  = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_load_cfg = arm && !disarm;
            end
            StArmed: begin
                w_emit = sti_valid && !disarm;
            end
            StRun: begin
                w_emit    = sti_valid && !disarm && (r_cnt == '0);
                w_cnt_dec = sti_valid && !disarm && (r_cnt != '0);
            end
            default: begin
                w_load_cfg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (extReset) begin
            r_pend_div   <= '0;
            r_pend_demux <= 1'b0;
            r_act_div    <= '0;
            r_demux_mode <= 1'b0;
            r_cnt        <= '0;
            r_sto_valid  <= 1'b0;
            r_sto_data   <= '0;
        end else begin
            r_pend_div   <= w_pend_div_nxt;
            r_pend_demux <= w_pend_demux_nxt;
            r_sto_valid  <= w_emit;
            if (w_load_cfg) begin
                r_act_div    <= w_pend_div_nxt;
                r_demux_mode <= w_pend_demux_nxt;
                r_cnt        <= '0;
            end else if (w_emit) begin
                r_cnt <= r_act_div;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_emit) begin
                r_sto_data <= r_demux_mode ? demux_data : raw_data;
            end
        end
    end

    assign sto_valid  = r_sto_valid;
    assign sto_data   = r_sto_data;
    assign demux_mode = r_demux_mode;
    assign state      = r_state;

endmodule

// File: tb/tb_demux_sample_ctrl.sv
// Directed bench for demux_sample_ctrl: inputs driven just after each rising edge,
// registered outputs checked 1 time unit after the following rising edge.
module tb_demux_sample_ctrl;

    localparam int unsigned DIV_W = 24;
    localparam int unsigned DW    = 32;

    logic             clock = 1'b0;
    logic             extReset;
    logic             wr_divider;
    logic             wr_flags;
    logic [DIV_W-1:0] cfg_data;
    logic             arm;
    logic             disarm;
    logic             sti_valid;
    logic [DW-1:0]    raw_data;
    logic [DW-1:0]    demux_data;
    logic             sto_valid;
    logic [DW-1:0]    sto_data;
    logic             demux_mode;
    logic [1:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    demux_sample_ctrl #(
        .DIV_W (DIV_W),
        .DW    (DW)
    ) u_dut (
        .clock      (clock),
        .extReset   (extReset),
        .wr_divider (wr_divider),
        .wr_flags   (wr_flags),
        .cfg_data   (cfg_data),
        .arm        (arm),
        .disarm     (disarm),
        .sti_valid  (sti_valid),
        .raw_data   (raw_data),
        .demux_data (demux_data),
        .sto_valid  (sto_valid),
        .sto_data   (sto_data),
        .demux_mode (demux_mode),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_divider = 1'b0;
        wr_flags   = 1'b0;
        arm        = 1'b0;
        disarm     = 1'b0;
        sti_valid  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        extReset   = 1'b1;
        cfg_data   = '0;
        raw_data   = '0;
        demux_data = '0;
        idle_inputs();

        // 1: reset, then N=0 raw capture of 8 consecutive valids
        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(sto_valid), 32'd0);
        check("rst_data", sto_data, 32'd0);
        check("rst_demux", 32'(demux_mode), 32'd0);
        extReset = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t1_armed", 32'(state), 32'd1);
        check("t1_no_emit_armed", 32'(sto_valid), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            sti_valid  = 1'b1;
            raw_data   = 32'h1000_0000 + 32'(k);
            demux_data = 32'hDEAD_0000 + 32'(k);
            tick();
            check("t1_valid", 32'(sto_valid), 32'd1);
            check("t1_data", sto_data, 32'h1000_0000 + 32'(k));
            check("t1_state", 32'(state), 32'd2);
        end
        sti_valid = 1'b0;
        tick();
        check("t1_tail_valid", 32'(sto_valid), 32'd0);
        check("t1_hold_data", sto_data, 32'h1000_0008);

        // 2: divider 3 -> emits on valids 1, 5, 9 of 12
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        check("t2_disarm", 32'(state), 32'd0);
        wr_divider = 1'b1;
        cfg_data   = 24'd3;
        tick();
        wr_divider = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t2_armed", 32'(state), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            sti_valid = 1'b1;
            raw_data  = 32'h2000_0000 + 32'(k);
            tick();
            check("t2_valid", 32'(sto_valid), (k == 1 || k == 5 || k == 9) ? 32'd1 : 32'd0);
            check("t2_state", 32'(state), 32'd2);
            if (k == 1 || k == 5 || k == 9) check("t2_data", sto_data, 32'h2000_0000 + 32'(k));
        end
        sti_valid = 1'b0;

        // 3: wr_flags together with arm is forwarded into demux_mode
        disarm = 1'b1;
        tick();
        disarm   = 1'b0;
        wr_flags = 1'b1;
        cfg_data = 24'd1;
        arm      = 1'b1;
        tick();
        wr_flags = 1'b0;
        arm      = 1'b0;
        check("t3_demux_mode", 32'(demux_mode), 32'd1);
        check("t3_armed", 32'(state), 32'd1);
        sti_valid  = 1'b1;
        raw_data   = 32'h1111_1111;
        demux_data = 32'hA5A5_5A5A;
        tick();
        sti_valid = 1'b0;
        check("t3_valid", 32'(sto_valid), 32'd1);
        check("t3_data", sto_data, 32'hA5A5_5A5A);
        raw_data   = 32'h2222_2222;
        demux_data = 32'h3333_3333;
        tick();
        check("t3_tail_valid", 32'(sto_valid), 32'd0);
        check("t3_hold_data", sto_data, 32'hA5A5_5A5A);

        // 4: divider write during RUN leaves cadence at 1-in-4 until re-arm
        wr_divider = 1'b1;
        cfg_data   = 24'd7;
        tick();
        wr_divider = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            sti_valid  = 1'b1;
            demux_data = 32'h4000_0000 + 32'(k);
            tick();
            check("t4_old_cadence", 32'(sto_valid), (k == 4 || k == 8) ? 32'd1 : 32'd0);
            if (k == 4 || k == 8) check("t4_old_data", sto_data, 32'h4000_0000 + 32'(k));
        end
        sti_valid = 1'b0;
        disarm = 1'b1;
        tick();
        disarm = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            sti_valid  = 1'b1;
            demux_data = 32'h5000_0000 + 32'(k);
            tick();
            check("t4_new_cadence", 32'(sto_valid), (k == 1 || k == 9) ? 32'd1 : 32'd0);
            if (k == 1 || k == 9) check("t4_new_data", sto_data, 32'h5000_0000 + 32'(k));
        end

        // 5: counter now 0, so this valid qualifies; disarm suppresses it
        disarm     = 1'b1;
        demux_data = 32'h6666_6666;
        tick();
        disarm    = 1'b0;
        sti_valid = 1'b0;
        check("t5_no_emit", 32'(sto_valid), 32'd0);
        check("t5_idle", 32'(state), 32'd0);
        check("t5_data_held", sto_data, 32'h5000_0009);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_rearmed", 32'(state), 32'd1);
        sti_valid = 1'b1;
        tick();
        sti_valid = 1'b0;
        check("t5_run", 32'(state), 32'd2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_arm_in_run_ignored", 32'(state), 32'd2);

        // 6: reset mid-RUN with a qualifying valid in flight
        disarm = 1'b1;
        tick();
        disarm     = 1'b0;
        wr_divider = 1'b1;
        wr_flags   = 1'b1;
        cfg_data   = 24'd3;
        arm        = 1'b1;
        tick();
        wr_divider = 1'b0;
        wr_flags   = 1'b0;
        arm        = 1'b0;
        check("t6_fwd_demux", 32'(demux_mode), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            sti_valid  = 1'b1;
            demux_data = 32'h7000_0000 + 32'(k);
            tick();
            check("t6_pre_cadence", 32'(sto_valid), (k == 1) ? 32'd1 : 32'd0);
        end
        extReset = 1'b1;
        tick();
        extReset  = 1'b0;
        sti_valid = 1'b0;
        check("t6_rst_valid", 32'(sto_valid), 32'd0);
        check("t6_rst_state", 32'(state), 32'd0);
        check("t6_rst_data", sto_data, 32'd0);
        check("t6_rst_demux", 32'(demux_mode), 32'd0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t6_pend_demux_cleared", 32'(demux_mode), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            sti_valid  = 1'b1;
            raw_data   = 32'h8000_0000 + 32'(k);
            demux_data = 32'h9000_0000 + 32'(k);
            tick();
            check("t6_div_cleared_valid", 32'(sto_valid), 32'd1);
            check("t6_div_cleared_data", sto_data, 32'h8000_0000 + 32'(k));
        end
        sti_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
